hist_acc: RTL
=============

# hist_acc

Cell-histogram accumulator for the HOG feature path. Consumes one (orientation bin, gradient magnitude) sample per cycle for the pixels of one cell and accumulates magnitudes per bin in a dual-port RAM. After the last pixel of the cell it streams the NBINS bin totals downstream with valid/ready flow control, clearing each bin as it is consumed. Sits between the gradient/orientation stage and block normalisation.

## Interface
- NBINS, 9: number of orientation bins
- BIN_W, 4: bin index width; 2**BIN_W >= NBINS
- MAG_W, 8: magnitude width
- ACC_W, 12: accumulator width, also the RAM data width
- PIX_PER_CELL, 64: samples per cell

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_valid  in  1  input sample valid
- i_bin  in  BIN_W  orientation bin of sample
- i_mag  in  MAG_W  magnitude of sample
- o_ready  out  1  block accepts a sample this cycle
- o_valid  out  1  output bin valid
- o_bin  out  BIN_W  index of output bin
- o_hist  out  ACC_W  accumulated total of o_bin
- o_last  out  1  o_bin == NBINS-1
- i_ready  in  1  downstream accepts output
- o_err  out  1  one-cycle pulse: accepted sample had i_bin >= NBINS

## Operation
- FSM states: CLEAR, ACC, FLUSH, DRAIN. Reset enters CLEAR.
- CLEAR: writes 0 to addresses 0..NBINS-1 through port a, one per cycle, for NBINS cycles. o_ready=0. Then ACC.
- ACC: o_ready=1. A sample is accepted on i_valid && o_ready.
  - Accept cycle t: port b reads i_bin. bin, mag and valid are registered.
  - Cycle t+1: sum = base + mag, saturating at 2**ACC_W-1, is written on port a to the same bin.
  - Forwarding: the RAM read returns the pre-write value. If the previous cycle wrote the same bin, base is the registered previous sum. Otherwise base is the RAM data.
  - Result: back-to-back same-bin samples accumulate correctly at one sample per cycle.
- Out-of-range bin (i_bin >= NBINS): no RAM write, o_err pulses in cycle t+1. The sample still counts toward PIX_PER_CELL.
- Pixel counter: counts accepted samples. On the accept that makes the count PIX_PER_CELL, the counter resets to 0, o_ready drops next cycle, and the FSM goes to FLUSH.
- FLUSH: lasts 1 cycle so the last write commits. Port b addr = 0. Then DRAIN.
- DRAIN:
  - o_valid rises the cycle after entry, with o_bin=0 and o_hist equal to the RAM port b data.
  - While o_valid && !i_ready, the port b address is held, so o_hist stays stable.
  - On handshake of bin j: port a writes 0 to j. The port b address advances to j+1, and the next cycle shows bin j+1 (1 bin/cycle when i_ready=1).
  - Handshake with o_last: o_valid=0 next cycle, FSM returns to ACC, o_ready=1 next cycle.
- o_hist is gated to 0 when o_valid=0.
- Reset mid-operation: any state returns to CLEAR. Partial histograms are discarded by the clear pass.

## Timing
- Reset values: o_ready=0, o_valid=0, o_bin=0, o_hist=0, o_last=0, o_err=0. The FSM is in CLEAR and the pixel counter is 0.
- After rst_n deasserts, o_ready=1 in the (NBINS+1)th cycle.
- Accept-to-RAM-commit: 1 cycle (write in cycle t+1).
- Last accept (cycle t) to first o_valid: t+3 (t+1 FLUSH, t+2 first DRAIN read issued, t+3 data valid).
- Drain throughput: NBINS cycles minimum per cell.
- Dead time between the last accept and o_ready: NBINS+3 cycles when i_ready=1.
- Sample throughput in ACC: 1 per cycle.

## Structure
- Shared header hog_defs: FSM state encoding, default NBINS/BIN_W/MAG_W/ACC_W/PIX_PER_CELL.
- One sub-module: dp_ram2 with DATA_W=ACC_W and ADDR_W=BIN_W.
  - Port a: accumulate writes and clear writes.
  - Port b: accumulate reads and drain reads.
- Saturating adder, forwarding mux, pixel counter and drain index are local logic.

## Test plan
- Reset, i_valid=1 from cycle 0 -> o_ready=0 for 9 cycles, then 1. No o_valid.
- 64 back-to-back samples, bin=k%9, mag=1, i_ready=1 -> drain bin0=8, bins1..8=7. o_last only on bin 8. First o_valid 3 cycles after the last accept.
- 64 samples all bin 3, mag=10 (forwarding) -> bin3=640, all other bins 0.
- 64 samples bin 5, mag=255 -> bin5=4095 (saturated). Next cell with bin 5, mag=1 ×64 -> bin5=64, proving the drain cleared it.
- Random i_ready during drain, i_valid gaps during ACC -> each bin presented exactly once in order 0..8. o_hist/o_bin stable while stalled. Totals match the reference model.
- 30 samples, then rst_n=0 for 1 cycle, then a full cell of bin 2, mag=1 with one sample at i_bin=12 -> o_err single pulse, bin2=63, others 0, drain after exactly 64 accepts.

Source files
------------

// File: rtl/hist_acc_pkg.sv
// hist_acc_pkg: shared definitions for the HOG cell-histogram accumulator.
//   - default geometry (bins, widths, pixels per cell)
//   - FSM state encoding, also exported on the debug state port
package hist_acc_pkg;

    localparam int DEF_NBINS        = 9;
    localparam int DEF_BIN_W        = 4;
    localparam int DEF_MAG_W        = 8;
    localparam int DEF_ACC_W        = 12;
    localparam int DEF_PIX_PER_CELL = 64;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/hist_acc_dp_ram2.sv
// dp_ram2: simple dual-port RAM, one write port and one read port.
//   clk    : clock
//   we_a   : port a write enable
//   addr_a : port a write address
//   din_a  : port a write data
//   addr_b : port b read address
//   dout_b : port b registered read data (read-first: a same-cycle write to
//            the same address is not visible until the following read)
module dp_ram2 #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/hist_acc.sv
// hist_acc: per-cell orientation histogram accumulator.
//   Accumulates (bin, magnitude) samples for one cell into a dual-port RAM,
//   then streams the NBINS totals out, clearing each bin as it is consumed.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   i_valid/o_ready     : input sample handshake; i_bin, i_mag sample fields
//   o_valid/i_ready     : output bin handshake; o_bin, o_hist, o_last fields
//   o_err               : one-cycle pulse, an accepted sample had i_bin >= NBINS
//   state_dbg           : current FSM state
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   A producer holding valid keeps its data stable until the transfer; the
//   output side here never drops o_valid or changes o_bin/o_hist while stalled.
module hist_acc
    import hist_acc_pkg::*;
#(
    parameter int NBINS        = DEF_NBINS,
    parameter int BIN_W        = DEF_BIN_W,
    parameter int MAG_W        = DEF_MAG_W,
    parameter int ACC_W        = DEF_ACC_W,
    parameter int PIX_PER_CELL = DEF_PIX_PER_CELL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [BIN_W-1:0] i_bin,
    input  logic [MAG_W-1:0] i_mag,
    output logic             o_ready,
    output logic             o_valid,
    output logic [BIN_W-1:0] o_bin,
    output logic [ACC_W-1:0] o_hist,
    output logic             o_last,
    input  logic             i_ready,
    output logic             o_err,
    output state_t           state_dbg
);

    localparam int               CNT_W     = $clog2(PIX_PER_CELL + 1);
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(NBINS - 1);
    localparam logic [BIN_W:0]   NBINS_EXT = (BIN_W + 1)'(NBINS);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIX_PER_CELL - 1);

    state_t state, state_nxt;

    logic [BIN_W-1:0] clr_idx;
    logic [CNT_W-1:0] pix_cnt;

    // Stage 1: accepted sample, RAM read in flight
    logic             s1_valid;
    logic [BIN_W-1:0] s1_bin;
    logic [MAG_W-1:0] s1_mag;
    logic             s1_oor;

    // Previous accumulate write, used to bypass the read-first RAM
    logic             wr_valid;
    logic [BIN_W-1:0] wr_bin;
    logic [ACC_W-1:0] wr_sum;

    logic             out_valid;
    logic [BIN_W-1:0] out_bin;

    logic             we_a;
    logic [BIN_W-1:0] addr_a;
    logic [ACC_W-1:0] din_a;
    logic [BIN_W-1:0] addr_b;
    logic [ACC_W-1:0] dout_b;

    logic             accept;
    logic             cell_done;
    logic             handshake;
    logic             acc_we;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum;

    assign o_ready   = (state == ST_ACC);
    assign accept    = i_valid && o_ready;
    assign cell_done = accept && (pix_cnt == LAST_PIX);
    assign handshake = out_valid && i_ready;
    assign acc_we    = s1_valid && !s1_oor;

    // A write issued last cycle to the same bin is not yet in dout_b
    assign base     = (wr_valid && (wr_bin == s1_bin)) ? wr_sum : dout_b;
    assign sum_wide = {1'b0, base} + {{(ACC_W + 1 - MAG_W){1'b0}}, s1_mag};
    assign sum      = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == LAST_BIN) state_nxt = ST_ACC;
            ST_ACC:   if (cell_done) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_DRAIN;
            ST_DRAIN: if (handshake && (out_bin == LAST_BIN)) state_nxt = ST_ACC;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Port a: clear pass, drain-side clearing, or accumulate write
    always_comb begin
        we_a   = 1'b0;
        addr_a = s1_bin;
        din_a  = sum;
        if (state == ST_CLEAR) begin
            we_a   = 1'b1;
            addr_a = clr_idx;
            din_a  = '0;
        end else if (handshake) begin
            we_a   = 1'b1;
            addr_a = out_bin;
            din_a  = '0;
        end else if (acc_we) begin
            we_a = 1'b1;
        end
    end

    // Port b: sample bin in ACC; during drain re-read the presented bin while
    // stalled so o_hist holds, or fetch the next bin on a transfer.
    always_comb begin
        case (state)
            ST_FLUSH: addr_b = '0;
            ST_DRAIN: addr_b = handshake ? out_bin + BIN_W'(1) : out_bin;
            default:  addr_b = i_bin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            pix_cnt   <= '0;
            s1_valid  <= 1'b0;
            s1_bin    <= '0;
            s1_mag    <= '0;
            s1_oor    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_bin    <= '0;
            wr_sum    <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= (state == ST_CLEAR) ? clr_idx + BIN_W'(1) : '0;
            if (accept) begin
                pix_cnt <= cell_done ? '0 : pix_cnt + CNT_W'(1);
            end
            s1_valid <= accept;
            s1_bin   <= i_bin;
            s1_mag   <= i_mag;
            s1_oor   <= ({1'b0, i_bin} >= NBINS_EXT);
            wr_valid <= acc_we && (state != ST_CLEAR);
            wr_bin   <= s1_bin;
            wr_sum   <= sum;
            // First DRAIN cycle only issues the read of bin 0
            if (state == ST_DRAIN) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_bin   <= '0;
                end else if (i_ready) begin
                    if (out_bin == LAST_BIN) begin
                        out_valid <= 1'b0;
                        out_bin   <= '0;
                    end else begin
                        out_bin <= out_bin + BIN_W'(1);
                    end
                end
            end
        end
    end

    dp_ram2 #(
        .DATA_W (ACC_W),
        .ADDR_W (BIN_W)
    ) u_ram (
        .clk    (clk),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .addr_b (addr_b),
        .dout_b (dout_b)
    );

    assign o_valid   = out_valid;
    assign o_bin     = out_bin;
    assign o_hist    = out_valid ? dout_b : '0;
    assign o_last    = out_valid && (out_bin == LAST_BIN);
    assign o_err     = s1_valid && s1_oor;
    assign state_dbg = state;

endmodule
